// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared encodings, FSM states and width defaults for mem_dma
package mem_dma_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_COPY  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR,
        CP_RD,
        CP_WAIT,
        CP_WR
    } state_t;

endpackage

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-command memory initiator: READ, WRITE, block FILL and block COPY
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d, src_ptr, src_d, dst_ptr, dst_d;
    logic [DATA_W-1:0] wdata_d, rsp_data_d;
    logic              we_d, rsp_valid_d, done_d;
    logic [ADDR_W:0]   count, count_d;
    logic [ADDR_W:0]   len_full;

    // A zero length encodes the full address space, hence the extra counter bit.
    assign len_full  = (cmd_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cmd_len};
    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            count     <= '0;
        end else begin
            state     <= state_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            done      <= done_d;
            src_ptr   <= src_d;
            dst_ptr   <= dst_d;
            count     <= count_d;
        end
    end

    always_comb begin
        state_d     = state;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        done_d      = 1'b0;
        src_d       = src_ptr;
        dst_d       = dst_ptr;
        count_d     = count;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    case (cmd_op)
                        OP_READ: state_d = RD_WAIT;
                        OP_WRITE: begin
                            wdata_d = cmd_data;
                            we_d    = 1'b1;
                            count_d = CNT_ONE;
                            state_d = WR;
                        end
                        OP_FILL: begin
                            wdata_d = cmd_data;
                            we_d    = 1'b1;
                            count_d = len_full;
                            state_d = WR;
                        end
                        default: begin
                            src_d   = cmd_addr;
                            dst_d   = cmd_dst;
                            count_d = len_full;
                            state_d = CP_RD;
                        end
                    endcase
                end
            end
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            // WRITE is a one-byte FILL; the write enable stays up until the count runs out.
            WR: begin
                if (count == CNT_ONE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = mem_addr + ADDR_W'(1);
                    count_d = count - CNT_ONE;
                end
            end
            CP_RD: state_d = CP_WAIT;
            CP_WAIT: begin
                wdata_d = mem_rdata;
                addr_d  = dst_ptr;
                we_d    = 1'b1;
                state_d = CP_WR;
            end
            CP_WR: begin
                if (count == CNT_ONE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    src_d   = src_ptr + ADDR_W'(1);
                    dst_d   = dst_ptr + ADDR_W'(1);
                    addr_d  = src_ptr + ADDR_W'(1);
                    count_d = count - CNT_ONE;
                    state_d = CP_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - scoreboard bench for mem_dma against a 256x8 memory model
module tb_mem_dma;
    import mem_dma_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } wr_ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'h00, cmd_dst = 8'h00, cmd_len = 8'h00, cmd_data = 8'h00;
    logic       rsp_valid, done, busy, mem_we;
    logic [7:0] rsp_data, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     wr_idx = 0;
    wr_ev_t wr_log[$];
    wr_ev_t exp_wr[$];
    logic [7:0] exp_rsp[$];

    mem_dma dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_log.push_back('{cyc: cyc, addr: mem_addr, data: mem_wdata});
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        exp_mem[a] = d;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] dst,
                         input logic [7:0] len, input logic [7:0] d, output int t0);
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int tdone, output bit rsp_seen, output int rsp_cyc,
                             output logic [7:0] rsp_val);
        tdone    = -1;
        rsp_seen = 1'b0;
        rsp_cyc  = -1;
        rsp_val  = 8'hxx;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                rsp_cyc  = cyc;
                rsp_val  = rsp_data;
            end
            if (done) begin
                tdone = cyc;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_addr, mem_wdata, mem_we, rsp_valid, rsp_data, done, busy} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_values got addr=%h wdata=%h we=%b rv=%b rd=%h done=%b busy=%b required all zero",
                     mem_addr, mem_wdata, mem_we, rsp_valid, rsp_data, done, busy);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_in_rst got %b required 0", cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after got %b required 1", cmd_ready);
        end
        for (int i = 0; i < 256; i++) preload(8'(i), 8'(i) ^ 8'hC3);
        wr_idx = wr_log.size();
    endtask

    task automatic test_read();
        int t0, tdone, rcyc;
        bit seen;
        logic [7:0] rv, e;
        preload(8'h10, 8'hA5);
        issue(OP_READ, 8'h10, 8'h00, 8'h00, 8'h00, t0);
        exp_rsp.push_back(8'hA5);
        wait_done(tdone, seen, rcyc, rv);
        n_checks++;
        if (tdone !== t0 + 2 || rcyc !== t0 + 2) begin
            n_fail++;
            $display("FAIL read_timing got done=%0d rsp=%0d required %0d", tdone - t0, rcyc - t0, 2);
        end
        e = exp_rsp.pop_front();
        n_checks++;
        if (!seen || rv !== e) begin
            n_fail++;
            $display("FAIL read_data got seen=%b data=%h required %h", seen, rv, e);
        end
        n_checks++;
        if (wr_log.size() != wr_idx) begin
            n_fail++;
            $display("FAIL read_no_write got %0d writes required 0", wr_log.size() - wr_idx);
        end
        wr_idx = wr_log.size();
    endtask

    task automatic test_write();
        int t0, tdone, rcyc;
        bit seen;
        logic [7:0] rv, e;
        wr_ev_t ev;
        issue(OP_WRITE, 8'h20, 8'h00, 8'h00, 8'h3C, t0);
        exp_wr.push_back('{cyc: t0, addr: 8'h20, data: 8'h3C});
        exp_mem[8'h20] = 8'h3C;
        wait_done(tdone, seen, rcyc, rv);
        n_checks++;
        if (tdone !== t0 + 1) begin
            n_fail++;
            $display("FAIL write_done got %0d required %0d", tdone - t0, 1);
        end
        n_checks++;
        if (rsp_data !== 8'hA5 || seen) begin
            n_fail++;
            $display("FAIL write_rsp_hold got data=%h pulse=%b required A5/0", rsp_data, seen);
        end
        while (exp_wr.size() > 0) begin
            ev = exp_wr.pop_front();
            n_checks++;
            if (wr_idx >= wr_log.size() || wr_log[wr_idx] !== ev) begin
                n_fail++;
                $display("FAIL write_ev[%0d] got %h required %h", wr_idx, wr_log[wr_idx], ev);
            end
            wr_idx++;
        end
        n_checks++;
        if (wr_log.size() != wr_idx) begin
            n_fail++;
            $display("FAIL write_extra got %0d required %0d", wr_log.size(), wr_idx);
        end
        wr_idx = wr_log.size();
        issue(OP_READ, 8'h20, 8'h00, 8'h00, 8'h00, t0);
        exp_rsp.push_back(exp_mem[8'h20]);
        wait_done(tdone, seen, rcyc, rv);
        e = exp_rsp.pop_front();
        n_checks++;
        if (!seen || rv !== e) begin
            n_fail++;
            $display("FAIL write_readback got seen=%b data=%h required %h", seen, rv, e);
        end
    endtask

    task automatic test_fill_wrap();
        int t0, tdone, rcyc;
        bit seen;
        logic [7:0] rv;
        wr_ev_t ev;
        issue(OP_FILL, 8'hFE, 8'h00, 8'd4, 8'h77, t0);
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back('{cyc: t0 + i, addr: 8'(8'hFE + i), data: 8'h77});
            exp_mem[8'(8'hFE + i)] = 8'h77;
        end
        wait_done(tdone, seen, rcyc, rv);
        n_checks++;
        if (tdone !== t0 + 4) begin
            n_fail++;
            $display("FAIL fill_done got %0d required %0d", tdone - t0, 4);
        end
        while (exp_wr.size() > 0) begin
            ev = exp_wr.pop_front();
            n_checks++;
            if (wr_idx >= wr_log.size() || wr_log[wr_idx] !== ev) begin
                n_fail++;
                $display("FAIL fill_ev[%0d] got %h required %h", wr_idx, wr_log[wr_idx], ev);
            end
            wr_idx++;
        end
        n_checks++;
        if (wr_log.size() != wr_idx) begin
            n_fail++;
            $display("FAIL fill_extra got %0d required %0d", wr_log.size(), wr_idx);
        end
        wr_idx = wr_log.size();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem[8'(8'hFE + i)] !== exp_mem[8'(8'hFE + i)]) begin
                n_fail++;
                $display("FAIL fill_mem[%h] got %h required %h", 8'(8'hFE + i),
                         mem[8'(8'hFE + i)], exp_mem[8'(8'hFE + i)]);
            end
        end
    endtask

    task automatic test_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] v0);
        int t0, tdone, rcyc;
        bit seen;
        logic [7:0] rv, b;
        wr_ev_t ev;
        preload(src, v0);
        preload(8'(src + 1), 8'(v0 + 1));
        preload(8'(src + 2), 8'(v0 + 2));
        issue(OP_COPY, src, dst, 8'd3, 8'h00, t0);
        for (int i = 0; i < 3; i++) begin
            b = exp_mem[8'(src + i)];
            exp_wr.push_back('{cyc: t0 + 2 + 3 * i, addr: 8'(dst + i), data: b});
            exp_mem[8'(dst + i)] = b;
        end
        wait_done(tdone, seen, rcyc, rv);
        n_checks++;
        if (tdone !== t0 + 9) begin
            n_fail++;
            $display("FAIL copy_done got %0d required %0d", tdone - t0, 9);
        end
        while (exp_wr.size() > 0) begin
            ev = exp_wr.pop_front();
            n_checks++;
            if (wr_idx >= wr_log.size() || wr_log[wr_idx] !== ev) begin
                n_fail++;
                $display("FAIL copy_ev[%0d] got %h required %h", wr_idx, wr_log[wr_idx], ev);
            end
            wr_idx++;
        end
        n_checks++;
        if (wr_log.size() != wr_idx) begin
            n_fail++;
            $display("FAIL copy_extra got %0d required %0d", wr_log.size(), wr_idx);
        end
        wr_idx = wr_log.size();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem[8'(dst + i)] !== exp_mem[8'(dst + i)]) begin
                n_fail++;
                $display("FAIL copy_mem[%h] got %h required %h", 8'(dst + i),
                         mem[8'(dst + i)], exp_mem[8'(dst + i)]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int t0;
        wr_ev_t ev;
        issue(OP_FILL, 8'h00, 8'h00, 8'd0, 8'hEE, t0);
        for (int i = 0; i < 5; i++) begin
            exp_wr.push_back('{cyc: t0 + i, addr: 8'(i), data: 8'hEE});
            exp_mem[8'(i)] = 8'hEE;
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_edge got we=%b done=%b busy=%b required 0/0/0", mem_we, done, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_after got done=%b ready=%b required 0/1", done, cmd_ready);
            end
        end
        while (exp_wr.size() > 0) begin
            ev = exp_wr.pop_front();
            n_checks++;
            if (wr_idx >= wr_log.size() || wr_log[wr_idx] !== ev) begin
                n_fail++;
                $display("FAIL rst_ev[%0d] got %h required %h", wr_idx, wr_log[wr_idx], ev);
            end
            wr_idx++;
        end
        n_checks++;
        if (wr_log.size() != wr_idx || mem[5] !== exp_mem[5]) begin
            n_fail++;
            $display("FAIL rst_extra got writes=%0d mem5=%h required %0d/%h",
                     wr_log.size(), mem[5], wr_idx, exp_mem[5]);
        end
        wr_idx = wr_log.size();
    endtask

    task automatic test_busy_ignore();
        int t0, tdone, rcyc;
        bit seen;
        logic [7:0] rv;
        issue(OP_FILL, 8'hA0, 8'h00, 8'd8, 8'h11, t0);
        for (int i = 0; i < 8; i++) exp_mem[8'(8'hA0 + i)] = 8'h11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd_op    = OP_WRITE;
            cmd_addr  = 8'hB0;
            cmd_data  = 8'h99;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ready got ready=%b busy=%b required 0/1", cmd_ready, busy);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(tdone, seen, rcyc, rv);
        n_checks++;
        if (tdone !== t0 + 8) begin
            n_fail++;
            $display("FAIL busy_done got %0d required %0d", tdone - t0, 8);
        end
        n_checks++;
        if (wr_log.size() - wr_idx != 8 || mem[8'hB0] !== exp_mem[8'hB0] || mem[8'hA7] !== 8'h11) begin
            n_fail++;
            $display("FAIL busy_ignored got writes=%0d memB0=%h memA7=%h required 8/%h/11",
                     wr_log.size() - wr_idx, mem[8'hB0], mem[8'hA7], exp_mem[8'hB0]);
        end
        wr_idx = wr_log.size();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_fill_wrap();
        test_copy(8'h40, 8'h80, 8'h01);
        test_copy(8'h50, 8'h51, 8'h09);
        test_reset_mid_fill();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Memory initiator for the 256x8 main memory. It drives the memory's address, write-data and write-enable inputs and consumes its read-data output.
- Memory timing it is built against:
  - Read: address sampled at posedge; data_out updated right after that posedge.
  - Write: committed at the negedge using the current address, data and write-enable.
- Accepts one command at a time from the CPU/loader: single READ, single WRITE, block FILL, or block COPY.

Parameters:
- ADDR_W, 8, memory address width; also the width of the length field.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE and when rst is low.
- cmd_op  in  2  operation: 0 READ, 1 WRITE, 2 FILL, 3 COPY.
- cmd_addr  in  ADDR_W  READ/WRITE/FILL address; COPY source.
- cmd_dst  in  ADDR_W  COPY destination; ignored otherwise.
- cmd_len  in  ADDR_W  FILL/COPY byte count; 0 means 2^ADDR_W.
- cmd_data  in  DATA_W  WRITE/FILL data.
- rsp_valid  out  1  one-cycle pulse carrying READ data.
- rsp_data  out  DATA_W  READ result; holds its value until the next READ.
- done  out  1  one-cycle pulse when any operation completes.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_we  out  1  registered memory write enable.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: mem_addr=0, mem_wdata=0, mem_we=0, rsp_valid=0, rsp_data=0, done=0, busy=0, state=IDLE.
- Reset mid-operation: rst at any edge aborts the operation, forces mem_we=0 at that edge, and emits no done.
- Handshake:
  - A command is accepted at the edge T where cmd_valid && cmd_ready.
  - Command fields are sampled at T only.
  - Only one operation is in flight; cmd_valid is ignored while busy.
- FSM states: IDLE, RD_WAIT, RD_CAP, WR, CP_RD, CP_WAIT, CP_WR.
- READ:
  - At T: mem_addr=cmd_addr, mem_we=0, next state RD_WAIT.
  - T+1: memory samples the address; next state RD_CAP.
  - T+2: rsp_data=mem_rdata; rsp_valid and done high for the cycle starting at T+2; return to IDLE.
- WRITE:
  - At T: mem_addr=cmd_addr, mem_wdata=cmd_data, mem_we=1; next state WR.
  - The memory commits at the negedge inside cycle T.
  - T+1: mem_we=0, done pulse, return to IDLE.
- FILL, N bytes:
  - mem_we is high continuously for cycles T..T+N-1.
  - mem_addr = cmd_addr+i in cycle T+i; mem_wdata = cmd_data throughout.
  - T+N: mem_we=0, done pulse.
- COPY, N bytes, 3 cycles per byte, byte i starting at Ti = T+3i:
  - Ti: mem_addr=src+i, mem_we=0 (CP_RD).
  - Ti+1: wait (CP_WAIT).
  - Ti+2: mem_wdata=mem_rdata, mem_addr=dst+i, mem_we=1 (CP_WR).
  - Done pulse at T+3N; mem_we=0 at that edge.
- Arithmetic:
  - All address increments wrap modulo 2^ADDR_W, e.g. 8'hFF+1 = 8'h00.
  - The remaining count is an ADDR_W+1-bit down-counter loaded with (cmd_len==0 ? 2^ADDR_W : cmd_len).
- Overlap: COPY proceeds strictly ascending, byte by byte. With dst = src+1, every destination byte ends up equal to the original mem[src]; this is defined behaviour.
- mem_we is never high outside the WR and CP_WR write cycles, or the FILL run.
- busy goes high at T and drops at the done edge. cmd_ready is low for the whole of that window.

Decomposition:
- Package mem_dma_pkg holds:
  - op encodings OP_READ=2'd0, OP_WRITE=2'd1, OP_FILL=2'd2, OP_COPY=2'd3;
  - the FSM state enum;
  - ADDR_W/DATA_W defaults.
- No sub-module: a single FSM plus address and length counters is the natural size.

Test Plan:
1. Preload mem[0x10]=0xA5; READ addr 0x10 accepted at T -> rsp_valid=done=1 at T+2, rsp_data=0xA5; mem_we stays 0 throughout.
2. WRITE 0x3C to 0x20 at T -> mem_we=1 for exactly cycle T; done at T+1; a following READ of 0x20 returns 0x3C.
3. FILL addr 0xFE, len 4, data 0x77 -> mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] = 0x77 (wrap); mem[0x02] unchanged; done at T+4.
4. Preload mem[0x40..0x42]={1,2,3}; COPY src 0x40, dst 0x80, len 3 -> mem[0x80..0x82]={1,2,3}; done at T+9; mem_we high only at T+2, T+5, T+8.
5. Overlap COPY src 0x50, dst 0x51, len 3, mem[0x50]=0x9 -> mem[0x51..0x53]=0x9.
6. Reset/handshake:
   - FILL len 0 started; rst at T+5 -> mem_we=0 at that edge, no done, mem[0..4] written, mem[5] unchanged, cmd_ready=1 after rst drops.
   - cmd_valid pulses while busy are ignored.
